// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: state encoding, draw command
// codes and screen coordinate widths.
package frame_sequencer_pkg;

  // Screen coordinate widths
  localparam int X_W = 9;
  localparam int Y_W = 8;

  // Command codes presented on start to the draw block
  localparam logic [2:0] START_NONE   = 3'd0;
  localparam logic [2:0] START_BALL   = 3'd1;
  localparam logic [2:0] START_PISTON = 3'd2;
  localparam logic [2:0] START_PVNRT  = 3'd3;
  localparam logic [2:0] START_METER  = 3'd4;

  // Sequencer states, in the order a frame walks through them
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CLR_ISS   = 4'd1,
    S_CLR_WAIT  = 4'd2,
    S_FETCH0    = 4'd3,
    S_CAP0      = 4'd4,
    S_PIST_ISS  = 4'd5,
    S_PIST_WAIT = 4'd6,
    S_FETCH     = 4'd7,
    S_CAP       = 4'd8,
    S_BALL_ISS  = 4'd9,
    S_BALL_WAIT = 4'd10,
    S_DONE      = 4'd11
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_wait_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting on the draw block and
// flags the cycle on which the allowed budget of TIMEOUT cycles runs out.
module wait_watchdog #(
  parameter int TIMEOUT = 262143
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count wait cycles; cleared while the command is being issued so the
  // first wait cycle sees zero. Holds at the limit rather than wrapping.
  always_ff @(posedge clk) begin
    if (!Reset_n || clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // The last permitted wait cycle is the one with count == TIMEOUT-1
  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler in front of the draw block: clear, piston chain
// (which also draws particle 0), then one ball per remaining particle.
//
// Draw handshake: a command is a single-cycle pulse on clear or start
// (never both). draw_plot is draw's busy flag; it may still read 0 in
// the first cycle after a pulse, so each wait ignores that cycle and then
// completes on the first cycle draw_plot is 0. xIn/yIn are stable before
// and throughout every start pulse.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int N_PART  = 8,
  parameter int TIMEOUT = 262143
) (
  input  logic                        clk,
  input  logic                        Reset_n,
  input  logic                        frame_tick,
  input  logic [$clog2(N_PART):0]     num_active,
  input  logic [2:0]                  mode_in,
  input  logic [6:0]                  meter_in,
  input  logic [7:0]                  height_in,
  input  logic                        draw_plot,
  output logic [$clog2(N_PART)-1:0]   part_addr,
  input  logic [X_W-1:0]              part_x,
  input  logic [Y_W-1:0]              part_y,
  output logic [2:0]                  start,
  output logic                        clear,
  output logic [X_W-1:0]              xIn,
  output logic [Y_W-1:0]              yIn,
  output logic [2:0]                  mode,
  output logic [6:0]                  meter,
  output logic [7:0]                  pistonHeight,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  overrun,
  output logic                        timeout_err,
  output seq_state_t                  dbgState
);

  localparam int AW = $clog2(N_PART);
  localparam int CW = AW + 1;

  seq_state_t    state;
  seq_state_t    stateNext;
  logic [AW-1:0] addrNext;
  logic [CW-1:0] nCount;
  logic [CW-1:0] nClamp;
  logic          pending;
  logic          waitFirst;
  logic          accept;
  logic          timeoutHit;
  logic          wdClr;
  logic          wdEn;
  logic          wdExpired;

  assign dbgState = state;

  wait_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .Reset_n (Reset_n),
    .clr     (wdClr),
    .en      (wdEn),
    .expired (wdExpired)
  );

  // Clamp the requested particle count into 1..N_PART
  always_comb begin
    nClamp = num_active;
    if (num_active == '0) begin
      nClamp = CW'(1);
    end else if (num_active > CW'(N_PART)) begin
      nClamp = CW'(N_PART);
    end
  end

  // Next-state, table address and watchdog control
  always_comb begin
    stateNext  = state;
    addrNext   = part_addr;
    accept     = 1'b0;
    timeoutHit = 1'b0;
    wdClr      = 1'b0;
    wdEn       = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_tick || pending) begin
          accept    = 1'b1;
          stateNext = S_CLR_ISS;
        end
      end
      S_CLR_ISS: begin
        wdClr     = 1'b1;
        stateNext = S_CLR_WAIT;
      end
      S_CLR_WAIT: begin
        wdEn = 1'b1;
        if (!waitFirst && !draw_plot) begin
          addrNext  = '0;
          stateNext = S_FETCH0;
        end else if (wdExpired) begin
          timeoutHit = 1'b1;
          stateNext  = S_IDLE;
        end
      end
      S_FETCH0: stateNext = S_CAP0;
      S_CAP0:   stateNext = S_PIST_ISS;
      S_PIST_ISS: begin
        wdClr     = 1'b1;
        stateNext = S_PIST_WAIT;
      end
      S_PIST_WAIT: begin
        wdEn = 1'b1;
        if (!waitFirst && !draw_plot) begin
          if (nCount == CW'(1)) begin
            stateNext = S_DONE;
          end else begin
            addrNext  = AW'(1);
            stateNext = S_FETCH;
          end
        end else if (wdExpired) begin
          timeoutHit = 1'b1;
          stateNext  = S_IDLE;
        end
      end
      S_FETCH: stateNext = S_CAP;
      S_CAP:   stateNext = S_BALL_ISS;
      S_BALL_ISS: begin
        wdClr     = 1'b1;
        stateNext = S_BALL_WAIT;
      end
      S_BALL_WAIT: begin
        wdEn = 1'b1;
        if (!waitFirst && !draw_plot) begin
          if ((CW'(part_addr) + CW'(1)) == nCount) begin
            stateNext = S_DONE;
          end else begin
            addrNext  = part_addr + AW'(1);
            stateNext = S_FETCH;
          end
        end else if (wdExpired) begin
          timeoutHit = 1'b1;
          stateNext  = S_IDLE;
        end
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // State register and state-decoded outputs, registered against the next state
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      part_addr  <= '0;
      waitFirst  <= 1'b0;
      clear      <= 1'b0;
      start      <= START_NONE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= stateNext;
      part_addr  <= addrNext;
      waitFirst  <= wdClr;
      clear      <= (stateNext == S_CLR_ISS);
      busy       <= (stateNext != S_IDLE);
      frame_done <= (stateNext == S_DONE);
      if (stateNext == S_PIST_ISS) begin
        start <= START_PISTON;
      end else if (stateNext == S_BALL_ISS) begin
        start <= START_BALL;
      end else begin
        start <= START_NONE;
      end
    end
  end

  // Frame snapshot, particle coordinate capture and ball count
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      mode         <= '0;
      meter        <= '0;
      pistonHeight <= '0;
      nCount       <= CW'(1);
      xIn          <= '0;
      yIn          <= '0;
    end else begin
      if (accept) begin
        mode         <= mode_in;
        meter        <= meter_in;
        pistonHeight <= height_in;
        nCount       <= nClamp;
      end
      if ((state == S_CAP0) || (state == S_CAP)) begin
        xIn <= part_x;
        yIn <= part_y;
      end
    end
  end

  // Tick bookkeeping (pending flag, saturating overrun) and sticky timeout
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      pending     <= 1'b0;
      overrun     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (timeoutHit) begin
        timeout_err <= 1'b1;
      end
      if (timeoutHit || accept) begin
        pending <= 1'b0;
      end else if (frame_tick && (state != S_IDLE)) begin
        pending <= 1'b1;
      end
      if (frame_tick && (state != S_IDLE) && pending && (overrun != 8'hFF)) begin
        overrun <= overrun + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a draw/particle-table responder, a command
// monitor, a command-stream reference model and one task per scenario.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int N_PART  = 8;
  localparam int TIMEOUT = 100;
  localparam int AW      = 3;
  localparam int CW      = 4;
  localparam int W       = 21;  // {clear, start[2:0], x[8:0], y[7:0]}

  logic          clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic [CW-1:0] num_active = '0;
  logic [2:0]    mode_in = '0;
  logic [6:0]    meter_in = '0;
  logic [7:0]    height_in = '0;
  logic          draw_plot = 1'b0;
  logic [8:0]    part_x = '0;
  logic [7:0]    part_y = '0;
  logic [AW-1:0] part_addr;
  logic [2:0]    start;
  logic          clear;
  logic [8:0]    xIn;
  logic [7:0]    yIn;
  logic [2:0]    mode;
  logic [6:0]    meter;
  logic [7:0]    pistonHeight;
  logic          busy;
  logic          frame_done;
  logic [7:0]    overrun;
  logic          timeout_err;
  seq_state_t    dbgState;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           doneCnt = 0;
  int           collisions = 0;
  logic [8:0]   tblX[N_PART];
  logic [7:0]   tblY[N_PART];
  int           busyLen = 5;
  bit           plotStuck = 1'b0;
  int           drawRemain = 0;
  logic [AW-1:0] addrPrev = '0;

  frame_sequencer #(
    .N_PART  (N_PART),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .num_active   (num_active),
    .mode_in      (mode_in),
    .meter_in     (meter_in),
    .height_in    (height_in),
    .draw_plot    (draw_plot),
    .part_addr    (part_addr),
    .part_x       (part_x),
    .part_y       (part_y),
    .start        (start),
    .clear        (clear),
    .xIn          (xIn),
    .yIn          (yIn),
    .mode         (mode),
    .meter        (meter),
    .pistonHeight (pistonHeight),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .dbgState     (dbgState)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded, required finish before 500000");
    $fatal(1, "global time limit");
  end

  // Draw block and particle table responder (1-cycle table latency)
  initial forever begin
    @(negedge clk);
    part_x   = tblX[addrPrev];
    part_y   = tblY[addrPrev];
    addrPrev = part_addr;
    if (!Reset_n) drawRemain = 0;
    if (drawRemain > 0) begin
      draw_plot  = 1'b1;
      drawRemain = drawRemain - 1;
    end else begin
      draw_plot = 1'b0;
    end
    if (Reset_n && (clear || start != START_NONE)) drawRemain = busyLen;
    if (plotStuck) draw_plot = 1'b1;
  end

  // Command monitor
  initial forever begin
    @(negedge clk);
    if (Reset_n) begin
      if (clear && start != START_NONE) collisions++;
      if (clear) obs_q.push_back({1'b1, 3'd0, 17'd0});
      else if (start != START_NONE) obs_q.push_back({1'b0, start, xIn, yIn});
      if (frame_done) doneCnt++;
    end
  end

  // Reference model: expected command stream for one frame
  task automatic model_frame(input int numAct);
    int n;
    n = numAct;
    if (n < 1) n = 1;
    if (n > N_PART) n = N_PART;
    exp_q.push_back({1'b1, 3'd0, 17'd0});
    exp_q.push_back({1'b0, 3'd2, tblX[0], tblY[0]});
    for (int i = 1; i < n; i++) exp_q.push_back({1'b0, 3'd1, tblX[i], tblY[i]});
  endtask

  // Driver tasks
  task automatic apply_reset();
    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    plotStuck  = 1'b0;
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    doneCnt    = 0;
    collisions = 0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic random_table();
    for (int i = 0; i < N_PART; i++) begin
      tblX[i] = 9'($urandom_range(0, 511));
      tblY[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    int cyc;
    quiet = 0;
    cyc   = 0;
    while (quiet < 4 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_idle busy still 1 after %0d cycles, required 0", tag, cyc);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    Reset_n   = 1'b0;
    mode_in   = 3'd5;
    meter_in  = 7'd77;
    height_in = 8'd200;
    frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    vectors++;
    if ({start, clear, part_addr, xIn, yIn, mode, meter, pistonHeight, busy, frame_done,
         overrun, timeout_err} !== 53'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h required=0", {start, clear, part_addr, xIn, yIn, mode,
               meter, pistonHeight, busy, frame_done, overrun, timeout_err});
    end
    vectors++;
    if (dbgState !== S_IDLE) begin
      miscompares++;
      $display("FAIL reset_state got=%0d required=%0d", dbgState, S_IDLE);
    end
    Reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_pending busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_frame();
    apply_reset();
    tblX[0] = 9'd10; tblY[0] = 8'd20;
    tblX[1] = 9'd30; tblY[1] = 8'd40;
    tblX[2] = 9'd50; tblY[2] = 8'd60;
    num_active = 4'd3;
    busyLen    = 5;
    pulse_tick();
    vectors++;
    if ({busy, clear} !== 2'b11) begin
      miscompares++;
      $display("FAIL accept_timing busy,clear=%b required 11", {busy, clear});
    end
    wait_idle("single");
    model_frame(3);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_len got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_cmd[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (doneCnt != 1 || collisions != 0) begin
      miscompares++;
      $display("FAIL single_done done=%0d coll=%0d required 1,0", doneCnt, collisions);
    end
  endtask

  task automatic test_clamp();
    int balls;
    apply_reset();
    random_table();
    busyLen    = 3;
    num_active = 4'd0;
    pulse_tick();
    wait_idle("clamp0");
    model_frame(0);
    vectors++;
    if (obs_q.size() != exp_q.size() || doneCnt != 1) begin
      miscompares++;
      $display("FAIL clamp0_len got=%0d/%0d required=%0d/1", obs_q.size(), doneCnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL clamp0_cmd[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    doneCnt    = 0;
    num_active = 4'd15;
    pulse_tick();
    wait_idle("clamp15");
    model_frame(15);
    balls = 0;
    foreach (obs_q[i]) if (obs_q[i][19:17] == 3'd1) balls++;
    vectors++;
    if (balls != 7 || doneCnt != 1) begin
      miscompares++;
      $display("FAIL clamp15_balls got=%0d done=%0d required=7,1", balls, doneCnt);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL clamp15_len got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL clamp15_cmd[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [2:0] m;
    logic [6:0] t;
    logic [7:0] h;
    int         na;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      random_table();
      na        = $urandom_range(0, 15);
      busyLen   = $urandom_range(1, 12);
      m         = 3'($urandom_range(0, 7));
      t         = 7'($urandom_range(0, 127));
      h         = 8'($urandom_range(0, 255));
      num_active = 4'(na);
      mode_in   = m;
      meter_in  = t;
      height_in = h;
      pulse_tick();
      wait_idle("rand");
      model_frame(na);
      vectors++;
      if (obs_q.size() != exp_q.size() || doneCnt != 1) begin
        miscompares++;
        $display("FAIL rand%0d_len got=%0d/%0d required=%0d/1", it, obs_q.size(), doneCnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand%0d_cmd[%0d] got=%h required=%h", it, i, obs_q[i], exp_q[i]);
        end
      end
      vectors++;
      if ({mode, meter, pistonHeight} !== {m, t, h} || collisions != 0) begin
        miscompares++;
        $display("FAIL rand%0d_snap got=%h coll=%0d required=%h,0", it, {mode, meter, pistonHeight},
                 collisions, {m, t, h});
      end
    end
  endtask

  task automatic test_ticks();
    int cyc;
    apply_reset();
    random_table();
    busyLen    = 6;
    num_active = 4'd3;
    pulse_tick();
    repeat (3) @(negedge clk);
    pulse_tick();
    repeat (3) @(negedge clk);
    pulse_tick();
    wait_idle("ticks");
    model_frame(3);
    model_frame(3);
    vectors++;
    if (doneCnt != 2 || overrun !== 8'd1) begin
      miscompares++;
      $display("FAIL ticks_extra done=%0d overrun=%0d required 2,1", doneCnt, overrun);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ticks_len got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ticks_cmd[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
      end
    end
    // Tick coincident with the DONE cycle
    apply_reset();
    num_active = 4'd2;
    pulse_tick();
    cyc = 0;
    while (!frame_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!frame_done) begin
      miscompares++;
      $display("FAIL done_wait frame_done=%b required 1", frame_done);
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_tick_idle busy=%b required 0", busy);
    end
    @(negedge clk);
    vectors++;
    if ({busy, clear} !== 2'b11) begin
      miscompares++;
      $display("FAIL done_tick_restart busy,clear=%b required 11", {busy, clear});
    end
    wait_idle("done_tick");
    vectors++;
    if (doneCnt != 2 || overrun !== 8'd0) begin
      miscompares++;
      $display("FAIL done_tick_frames done=%0d overrun=%0d required 2,0", doneCnt, overrun);
    end
  endtask

  task automatic test_overrun_saturate();
    apply_reset();
    random_table();
    busyLen    = 80;
    num_active = 4'd8;
    for (int k = 0; k < 300; k++) pulse_tick();
    wait_idle("sat");
    vectors++;
    if (overrun !== 8'd255 || doneCnt != 2) begin
      miscompares++;
      $display("FAIL overrun_sat overrun=%0d done=%0d required 255,2", overrun, doneCnt);
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] h1;
    logic [2:0] m1;
    logic [6:0] t1;
    apply_reset();
    random_table();
    busyLen    = 4;
    num_active = 4'd4;
    h1 = 8'($urandom_range(0, 255));
    m1 = 3'($urandom_range(0, 7));
    t1 = 7'($urandom_range(0, 127));
    height_in = h1;
    mode_in   = m1;
    meter_in  = t1;
    pulse_tick();
    height_in = ~h1;
    mode_in   = ~m1;
    meter_in  = ~t1;
    repeat (12) @(negedge clk);
    vectors++;
    if ({mode, meter, pistonHeight} !== {m1, t1, h1}) begin
      miscompares++;
      $display("FAIL snap_mid got=%h required=%h", {mode, meter, pistonHeight}, {m1, t1, h1});
    end
    wait_idle("snap");
    vectors++;
    if (pistonHeight !== h1) begin
      miscompares++;
      $display("FAIL snap_end got=%0d required=%0d", pistonHeight, h1);
    end
    pulse_tick();
    vectors++;
    if ({mode, meter, pistonHeight} !== {~m1, ~t1, ~h1}) begin
      miscompares++;
      $display("FAIL snap_next got=%h required=%h", {mode, meter, pistonHeight}, {~m1, ~t1, ~h1});
    end
    wait_idle("snap2");
  endtask

  task automatic test_watchdog();
    apply_reset();
    num_active = 4'd2;
    plotStuck  = 1'b1;
    pulse_tick();
    vectors++;
    if (clear !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_clear clear=%b required 1", clear);
    end
    for (int s = 1; s <= 100; s++) begin
      @(negedge clk);
      if (s == 50) frame_tick = 1'b1;
      if (s == 51) frame_tick = 1'b0;
    end
    vectors++;
    if ({timeout_err, busy} !== 2'b01 || dbgState !== S_CLR_WAIT) begin
      miscompares++;
      $display("FAIL wd_before err,busy=%b state=%0d required 01,%0d", {timeout_err, busy}, dbgState,
               S_CLR_WAIT);
    end
    @(negedge clk);
    vectors++;
    if ({timeout_err, busy} !== 2'b10 || dbgState !== S_IDLE || doneCnt != 0) begin
      miscompares++;
      $display("FAIL wd_expire err,busy=%b state=%0d done=%0d required 10,%0d,0",
               {timeout_err, busy}, dbgState, doneCnt, S_IDLE);
    end
    plotStuck = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if ({timeout_err, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL wd_sticky err,busy=%b required 10", {timeout_err, busy});
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    apply_reset();
    random_table();
    busyLen    = 8;
    num_active = 4'd4;
    pulse_tick();
    repeat (2) @(negedge clk);
    pulse_tick();
    cyc = 0;
    while (dbgState != S_BALL_WAIT && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (dbgState !== S_BALL_WAIT) begin
      miscompares++;
      $display("FAIL midrst_reach state=%0d required=%0d", dbgState, S_BALL_WAIT);
    end
    Reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({start, clear, part_addr, xIn, yIn, mode, meter, pistonHeight, busy, frame_done,
         overrun, timeout_err} !== 53'd0 || dbgState !== S_IDLE) begin
      miscompares++;
      $display("FAIL midrst_outputs got=%h state=%0d required=0,0", {start, clear, part_addr, xIn,
               yIn, mode, meter, pistonHeight, busy, frame_done, overrun, timeout_err}, dbgState);
    end
    Reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    doneCnt = 0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL midrst_pending busy=%b cmds=%0d required 0,0", busy, obs_q.size());
    end
    pulse_tick();
    wait_idle("midrst");
    model_frame(4);
    vectors++;
    if (obs_q.size() != exp_q.size() || doneCnt != 1) begin
      miscompares++;
      $display("FAIL midrst_len got=%0d/%0d required=%0d/1", obs_q.size(), doneCnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midrst_cmd[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    for (int i = 0; i < N_PART; i++) begin
      tblX[i] = '0;
      tblY[i] = '0;
    end
    test_reset();
    test_single_frame();
    test_clamp();
    test_random_frames();
    test_ticks();
    test_overrun_saturate();
    test_snapshot();
    test_watchdog();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
